freq_window_capture: RTL and testbench
======================================

FREQ_WINDOW_CAPTURE -- requirements
Module: freq_window_capture

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000: gate window length in clock cycles, legal range 2..2^24.
REQ-002 SHALL have parameter CNT_W, default 32: edge counter and result width.
REQ-003 SHALL have parameter CONTINUOUS, default 0: 1 = re-arm automatically after each capture, 0 = one window per start.
REQ-004 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sig_in  input  1  measured signal, asynchronous to clock.
REQ-007 SHALL have port start  input  1  single-cycle request to begin one window.
REQ-008 SHALL have port result_ready  input  1  consumer accepts result.
REQ-009 SHALL have port busy  output  1  high while a window is in progress or being captured.
REQ-010 SHALL have port result_valid  output  1  result holds an unconsumed measurement.
REQ-011 SHALL have port result  output  CNT_W  rising-edge count of the last completed window.
REQ-012 SHALL have port overflow  output  1  last result saturated; qualified by result_valid.
REQ-013 SHALL have port dropped  output  1  one-cycle pulse: unconsumed result overwritten.

Function
REQ-014 SHALL synchronise sig_in through two flops, then detect rising edges with a third flop: edge = s2 & ~s3.
REQ-015 SHALL implement FSM states IDLE, GATE, CAPTURE; busy = (state != IDLE).
REQ-016 IDLE -> GATE SHALL occur on the cycle after start=1 (CONTINUOUS=0) or unconditionally (CONTINUOUS=1); start SHALL be ignored outside IDLE.
REQ-017 On GATE entry, edge counter and gate counter SHALL be 0 and the overflow accumulator cleared.
REQ-018 GATE SHALL last exactly GATE_CYCLES clock cycles; each detected edge during those cycles SHALL add 1 to the edge counter.
REQ-019 Edge counter SHALL saturate at 2^CNT_W-1; any edge at saturation SHALL set the window overflow accumulator.
REQ-020 After the last GATE cycle, FSM SHALL spend exactly one cycle in CAPTURE; in that cycle result, overflow load from counter/accumulator, result_valid sets.
REQ-021 CAPTURE -> IDLE (CONTINUOUS=0) or CAPTURE -> GATE (CONTINUOUS=1); dead time between windows is therefore 1 cycle (continuous).
REQ-022 Edges detected in CAPTURE or IDLE SHALL not be counted.
REQ-023 Handshake: transfer occurs on a cycle with result_valid=1 and result_ready=1; result_valid clears the following cycle unless a capture loads in that same cycle.
REQ-024 result and overflow SHALL remain stable while result_valid=1 and no capture occurs.
REQ-025 Capture while result_valid=1 and result_ready=0 SHALL overwrite result, keep result_valid=1, pulse dropped for one cycle.
REQ-026 Capture coinciding with a handshake SHALL not pulse dropped; result_valid stays 1 with new data.
REQ-027 result_ready while result_valid=0 SHALL have no effect.

Reset
REQ-028 reset low SHALL immediately force state IDLE, busy=0, result_valid=0, result=0, overflow=0, dropped=0, synchroniser flops and all counters 0.
REQ-029 reset asserted mid-GATE SHALL discard the partial window; no capture occurs after release.
REQ-030 After reset release, CONTINUOUS=1 SHALL start its first window on the first clock edge, CONTINUOUS=0 SHALL wait for start.

Verification (GATE_CYCLES=10, CNT_W=4 unless stated)
REQ-031 CONTINUOUS=0, sig_in toggling every cycle (rising edge every 2 cycles, settled before start), start pulse -> busy high 11 cycles, result=5, overflow=0, result_valid until result_ready.
REQ-032 GATE_CYCLES=100, sig_in period 2 cycles (50 rising edges) -> result=15, overflow=1.
REQ-033 CONTINUOUS=1, result_ready held 0 across two windows -> dropped pulses once at second capture, result holds second window value.
REQ-034 CONTINUOUS=1, result_ready asserted exactly on second capture cycle -> dropped=0, result_valid stays 1, result = second window.
REQ-035 reset pulsed low at gate cycle 5 -> all outputs 0 at once, no result_valid after release; start during GATE is ignored.

Source files
------------

// File: rtl/freq_window_capture.sv
// rtl/freq_window_capture.sv - gated rising-edge counter (frequency meter) with result handshake
//
// Counts rising edges of an asynchronous input over a fixed window of
// GATE_CYCLES clock cycles. The result is held with a valid/ready
// handshake.
//
// Parameters
//   GATE_CYCLES  window length in clock cycles (2 .. 2^24)
//   CNT_W        edge counter / result width
//   CONTINUOUS   1: re-arm after every capture, 0: one window per start
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   sig_in        measured signal, asynchronous to clock
//   start         single-cycle request to begin one window (ignored unless idle)
//   result_ready  consumer accepts result
//   busy          window in progress or being captured
//   result_valid  result holds an unconsumed measurement
//   result        rising-edge count of the last completed window
//   overflow      last result saturated (qualified by result_valid)
//   dropped       one-cycle pulse: an unconsumed result was overwritten
module freq_window_capture #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 32,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             dropped
);

  // Gate counter runs 0 .. GATE_CYCLES-1, so $clog2 bits always suffice.
  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf_acc;
  logic              gate_done;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  assign gate_done = (gate_cnt == GATE_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (CONTINUOUS || start) begin
          state_next = GATE;
        end
      end
      GATE: begin
        if (gate_done) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = CONTINUOUS ? GATE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counters are held at zero outside GATE, which guarantees a clean start
  // on every GATE entry. CAPTURE still sees the final values because the
  // clear only lands on the edge that leaves CAPTURE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_acc  <= 1'b0;
    end else if (state != GATE) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (rise) begin
        if (edge_cnt == {CNT_W{1'b1}}) begin
          ovf_acc <= 1'b1;
        end else begin
          edge_cnt <= edge_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Result holding register. A capture always wins over a handshake in the
  // same cycle, so result_valid stays set with the fresh data. dropped fires
  // only when the old result was neither consumed nor about to be.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (state == CAPTURE) begin
        result       <= edge_cnt;
        overflow     <= ovf_acc;
        result_valid <= 1'b1;
        dropped      <= result_valid & ~result_ready;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_window_capture.sv
// tb/tb_freq_window_capture.sv - directed self-checking bench for freq_window_capture
module tb_freq_window_capture;

  logic clock;
  int   compared;
  int   mismatched;

  // u0: single-shot, 10-cycle gate
  logic       rst0, start0, ready0;
  logic       busy0, valid0, overflow0, dropped0;
  logic [3:0] result0;
  // u1: single-shot, 100-cycle gate (overflow)
  logic       rst1, start1, ready1;
  logic       busy1, valid1, overflow1, dropped1;
  logic [3:0] result1;
  // u2: continuous, 10-cycle gate
  logic       rst2, start2, ready2, sig2;
  logic       busy2, valid2, overflow2, dropped2;
  logic [3:0] result2;

  logic        sig_tog;
  logic [31:0] pat;

  freq_window_capture #(.GATE_CYCLES(10), .CNT_W(4), .CONTINUOUS(1'b0)) u0 (
    .clock(clock), .reset(rst0), .sig_in(sig_tog), .start(start0), .result_ready(ready0),
    .busy(busy0), .result_valid(valid0), .result(result0), .overflow(overflow0), .dropped(dropped0)
  );

  freq_window_capture #(.GATE_CYCLES(100), .CNT_W(4), .CONTINUOUS(1'b0)) u1 (
    .clock(clock), .reset(rst1), .sig_in(sig_tog), .start(start1), .result_ready(ready1),
    .busy(busy1), .result_valid(valid1), .result(result1), .overflow(overflow1), .dropped(dropped1)
  );

  freq_window_capture #(.GATE_CYCLES(10), .CNT_W(4), .CONTINUOUS(1'b1)) u2 (
    .clock(clock), .reset(rst2), .sig_in(sig2), .start(start2), .result_ready(ready2),
    .busy(busy2), .result_valid(valid2), .result(result2), .overflow(overflow2), .dropped(dropped2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running toggle: one rising edge every two clock cycles.
  initial begin
    sig_tog = 1'b0;
    forever begin
      @(negedge clock);
      sig_tog = ~sig_tog;
    end
  end

  task automatic test_reset;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0; sig2 = 1'b0;
    #1;
    compared++;
    if ({busy0, valid0, result0, overflow0, dropped0} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_u0_outputs: got %b expected 00000000", {busy0, valid0, result0, overflow0, dropped0});
    end
    compared++;
    if ({busy2, valid2, dropped2} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_u2_outputs: got %b expected 000", {busy2, valid2, dropped2});
    end
    repeat (3) @(negedge clock);
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(negedge clock);
    compared++;
    if (busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_waits_for_start: busy got %b expected 0", busy0);
    end
  endtask

  task automatic test_single_window;
    int busy_cnt;
    busy_cnt = 0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy0 === 1'b1) busy_cnt++;
      @(negedge clock);
    end
    compared++;
    if (busy_cnt != 11) begin
      mismatched++;
      $display("FAIL busy_length: got %0d cycles expected 11", busy_cnt);
    end
    compared++;
    if ({valid0, result0, overflow0} !== {1'b1, 4'd5, 1'b0}) begin
      mismatched++;
      $display("FAIL single_result: valid/result/ovf got %b/%0d/%b expected 1/5/0", valid0, result0, overflow0);
    end
    repeat (5) @(negedge clock);
    compared++;
    if ({valid0, result0} !== {1'b1, 4'd5}) begin
      mismatched++;
      $display("FAIL result_hold: valid/result got %b/%0d expected 1/5", valid0, result0);
    end
    ready0 = 1'b1;
    @(negedge clock);
    ready0 = 1'b0;
    compared++;
    if (valid0 !== 1'b0) begin
      mismatched++;
      $display("FAIL handshake_clear: valid got %b expected 0", valid0);
    end
    ready0 = 1'b1;
    repeat (2) @(negedge clock);
    ready0 = 1'b0;
    compared++;
    if ({valid0, busy0, dropped0} !== 3'b000) begin
      mismatched++;
      $display("FAIL ready_without_valid: valid/busy/dropped got %b expected 000", {valid0, busy0, dropped0});
    end
  endtask

  task automatic test_overflow;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    repeat (120) @(negedge clock);
    compared++;
    if ({valid1, result1, overflow1} !== {1'b1, 4'd15, 1'b1}) begin
      mismatched++;
      $display("FAIL overflow_saturate: valid/result/ovf got %b/%0d/%b expected 1/15/1", valid1, result1, overflow1);
    end
  endtask

  task automatic test_start_in_gate;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    repeat (3) @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    repeat (15) @(negedge clock);
    compared++;
    if ({busy0, valid0, result0} !== {1'b0, 1'b1, 4'd5}) begin
      mismatched++;
      $display("FAIL start_in_gate_ignored: busy/valid/result got %b/%b/%0d expected 0/1/5", busy0, valid0, result0);
    end
  endtask

  task automatic test_reset_mid_gate;
    bit seen;
    seen = 1'b0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    repeat (4) @(negedge clock);
    compared++;
    if (busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_gate_busy: busy got %b expected 1", busy0);
    end
    rst0 = 1'b0;
    #1;
    compared++;
    if ({busy0, valid0, result0, overflow0, dropped0} !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset_outputs: got %b expected 00000000", {busy0, valid0, result0, overflow0, dropped0});
    end
    repeat (2) @(negedge clock);
    rst0 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (valid0 === 1'b1 || busy0 === 1'b1) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL no_capture_after_reset: activity got %b expected 0", seen);
    end
  endtask

  // Rising edges at drive slots 2,4,6,10 (window 1: 3 counted, slot 10 lands
  // in CAPTURE) and 13,16 (window 2: 2 counted).
  task automatic start_cont;
    pat = 32'h0001_2454;
    ready2 = 1'b0;
    sig2 = 1'b0;
    rst2 = 1'b0;
    repeat (2) @(negedge clock);
    rst2 = 1'b1;
    sig2 = pat[1];
  endtask

  task automatic test_cont_drop;
    int drops;
    drops = 0;
    start_cont();
    for (int n = 2; n <= 26; n++) begin
      @(negedge clock);
      if (dropped2 === 1'b1) drops++;
      if (n - 1 == 12) begin
        compared++;
        if ({valid2, result2, overflow2} !== {1'b1, 4'd3, 1'b0}) begin
          mismatched++;
          $display("FAIL cont_first_window: valid/result/ovf got %b/%0d/%b expected 1/3/0", valid2, result2, overflow2);
        end
      end
      if (n - 1 == 22) begin
        compared++;
        if (busy2 !== 1'b1) begin
          mismatched++;
          $display("FAIL cont_busy_capture: busy got %b expected 1", busy2);
        end
      end
      if (n - 1 == 23) begin
        compared++;
        if ({valid2, result2, dropped2} !== {1'b1, 4'd2, 1'b1}) begin
          mismatched++;
          $display("FAIL cont_overwrite: valid/result/dropped got %b/%0d/%b expected 1/2/1", valid2, result2, dropped2);
        end
      end
      sig2 = pat[n];
    end
    compared++;
    if (drops != 1) begin
      mismatched++;
      $display("FAIL dropped_count: got %0d pulses expected 1", drops);
    end
  endtask

  task automatic test_cont_handshake;
    int drops;
    drops = 0;
    start_cont();
    for (int n = 2; n <= 27; n++) begin
      @(negedge clock);
      if (dropped2 === 1'b1) drops++;
      if (n - 1 == 23) begin
        compared++;
        if ({valid2, result2, dropped2} !== {1'b1, 4'd2, 1'b0}) begin
          mismatched++;
          $display("FAIL capture_with_handshake: valid/result/dropped got %b/%0d/%b expected 1/2/0", valid2, result2, dropped2);
        end
      end
      if (n - 1 == 25) begin
        compared++;
        if (valid2 !== 1'b0) begin
          mismatched++;
          $display("FAIL cont_consume: valid got %b expected 0", valid2);
        end
      end
      ready2 = ((n - 1) == 22) || ((n - 1) == 24);
      sig2 = pat[n];
    end
    compared++;
    if (drops != 0) begin
      mismatched++;
      $display("FAIL handshake_no_drop: got %0d pulses expected 0", drops);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    pat = 32'h0;
    test_reset();
    @(negedge clock);
    test_single_window();
    test_overflow();
    test_start_in_gate();
    test_reset_mid_gate();
    test_cont_drop();
    test_cont_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
